// File: rtl/clk_ratio_det.sv
// Divided-clock ratio detector: measures high/low run lengths of i_div_clk in the
// i_ref_clk domain and reports the locked ratio. Define CLK_RATIO_DET_SYNC_EN to add a 2-flop input synchronizer.

module clk_ratio_det #(
  parameter int RATIO_WIDTH = 4
) (
  input  logic                   i_ref_clk,
  input  logic                   i_rst_n,
  input  logic                   i_en,
  input  logic                   i_div_clk,
  output logic [RATIO_WIDTH-1:0] o_ratio,
  output logic [RATIO_WIDTH-1:0] o_high_cnt,
  output logic                   o_valid,
  output logic                   o_err,
  output logic                   o_stuck
);

  typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;

  localparam logic [RATIO_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [RATIO_WIDTH-1:0] CNT_ONE = RATIO_WIDTH'(1);
  localparam logic [RATIO_WIDTH:0]   P_MAX   = {1'b0, CNT_MAX};
  localparam logic [RATIO_WIDTH:0]   P_ONE   = (RATIO_WIDTH+1)'(1);

  logic s, s_q;

`ifdef CLK_RATIO_DET_SYNC_EN
  logic [1:0] sync_q;

  // NOTE: asynchronous active-low reset; every flop returns to a known value
  // as soon as i_rst_n falls, without waiting for a clock edge.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync_q <= '0;
    else          sync_q <= {sync_q[0], i_div_clk};
  end
  assign s = sync_q[1];
`else
  assign s = i_div_clk;
`endif

  state_t                 state_q, state_d;
  logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
  logic [RATIO_WIDTH-1:0] high_q, high_d;
  logic [RATIO_WIDTH-1:0] cand_q, cand_d;
  logic                   cand_vld_q, cand_vld_d;
  logic [RATIO_WIDTH-1:0] ratio_d, high_cnt_d;
  logic                   valid_d, err_d, stuck_d;

  logic rise, fall, edge_seen, expire;
  logic [RATIO_WIDTH:0] period;
  logic well_formed;

  assign rise      = s & ~s_q;
  assign fall      = ~s & s_q;
  assign edge_seen = rise | fall;

  // Low run may equal the high run or exceed it by one (odd divide ratios).
  assign period      = {1'b0, high_q} + {1'b0, cnt_q};
  assign well_formed = (({1'b0, cnt_q} == {1'b0, high_q}) ||
                        ({1'b0, cnt_q} == ({1'b0, high_q} + P_ONE))) &&
                       (period <= P_MAX);

  // NOTE: every combinational output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    high_d     = high_q;
    cand_d     = cand_q;
    cand_vld_d = cand_vld_q;
    ratio_d    = o_ratio;
    high_cnt_d = o_high_cnt;
    valid_d    = o_valid;
    err_d      = 1'b0;
    stuck_d    = o_stuck;
    expire     = 1'b0;

    unique case (state_q)
      IDLE: begin
        state_d = SYNC;
        cnt_d   = CNT_ONE;
      end
      SYNC: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
          stuck_d = 1'b0;
        end else if (fall) begin
          cnt_d   = CNT_ONE;
          stuck_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          state_d = LOW;
          high_d  = cnt_q;
          cnt_d   = CNT_ONE;
          stuck_d = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      LOW: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
          stuck_d = 1'b0;
          if (!well_formed) begin
            err_d      = 1'b1;
            valid_d    = 1'b0;
            cand_vld_d = 1'b0;
          end else if (!cand_vld_q) begin
            cand_d     = period[RATIO_WIDTH-1:0];
            cand_vld_d = 1'b1;
          end else if (period[RATIO_WIDTH-1:0] == cand_q) begin
            valid_d    = 1'b1;
            ratio_d    = period[RATIO_WIDTH-1:0];
            high_cnt_d = high_q;
          end else begin
            err_d   = 1'b1;
            valid_d = 1'b0;
            cand_d  = period[RATIO_WIDTH-1:0];
          end
        end else if (cnt_q == CNT_MAX) begin
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Counter stays saturated after expiry so a still-stuck input keeps o_stuck set.
    if (expire) begin
      state_d    = SYNC;
      stuck_d    = 1'b1;
      valid_d    = 1'b0;
      cand_vld_d = 1'b0;
    end

    if (!i_en) begin
      state_d    = IDLE;
      cnt_d      = '0;
      high_d     = '0;
      cand_d     = '0;
      cand_vld_d = 1'b0;
      ratio_d    = '0;
      high_cnt_d = '0;
      valid_d    = 1'b0;
      err_d      = 1'b0;
      stuck_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      s_q        <= 1'b0;
      cnt_q      <= '0;
      high_q     <= '0;
      cand_q     <= '0;
      cand_vld_q <= 1'b0;
      o_ratio    <= '0;
      o_high_cnt <= '0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
      o_stuck    <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s;
      cnt_q      <= cnt_d;
      high_q     <= high_d;
      cand_q     <= cand_d;
      cand_vld_q <= cand_vld_d;
      o_ratio    <= ratio_d;
      o_high_cnt <= high_cnt_d;
      o_valid    <= valid_d;
      o_err      <= err_d;
      o_stuck    <= stuck_d;
    end
  end

endmodule

// File: tb/tb_clk_ratio_det.sv
// Self-checking bench for clk_ratio_det: directed scenarios plus random waveforms,
// scored every cycle against a timestamp-based reference model.

module tb_clk_ratio_det;

  localparam int W       = 4;
  localparam int CNT_MAX = (1 << W) - 1;
`ifdef CLK_RATIO_DET_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int LOCK4_LAT  = 2 * 4 + 1 + LAT;
  localparam int STUCK_LAT  = CNT_MAX + 1 + LAT;

  logic         clk, rst_n, en, div_clk;
  logic [W-1:0] ratio, high_cnt;
  logic         valid, err, stuck;

  int total = 0;
  int bad   = 0;

  clk_ratio_det #(.RATIO_WIDTH(W)) dut (
    .i_ref_clk (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_div_clk (div_clk),
    .o_ratio   (ratio),
    .o_high_cnt(high_cnt),
    .o_valid   (valid),
    .o_err     (err),
    .o_stuck   (stuck)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: tracks edge timestamps and applies the period rules directly.
  int           m_t = 0;
  bit           m_active, m_synced, m_have_fall;
  int           m_rise_t, m_fall_t, m_last_edge;
  int           m_cand;
  bit           m_cand_vld;
  logic [W-1:0] m_ratio, m_high;
  logic         m_valid, m_err, m_stuck;
  logic         h1, h2, sp;

  int cyc = 0;
  int err_seen = 0;
  int first_valid = -1;
  int first_stuck = -1;

  task model_reset();
    m_active = 0; m_synced = 0; m_have_fall = 0;
    m_rise_t = 0; m_fall_t = 0; m_last_edge = 0;
    m_cand = 0; m_cand_vld = 0;
    m_ratio = '0; m_high = '0; m_valid = 0; m_err = 0; m_stuck = 0;
    h1 = 0; h2 = 0; sp = 0;
  endtask

  task model_period(input int hh, input int ll);
    int p;
    p = hh + ll;
    if (!((ll == hh || ll == hh + 1) && p <= CNT_MAX)) begin
      m_err = 1; m_valid = 0; m_cand_vld = 0;
    end else if (!m_cand_vld) begin
      m_cand = p; m_cand_vld = 1;
    end else if (p == m_cand) begin
      m_valid = 1; m_ratio = W'(p); m_high = W'(hh);
    end else begin
      m_err = 1; m_valid = 0; m_cand = p;
    end
  endtask

  task model_step(input logic e, input logic d);
    logic s, rise, fall;
    s = (LAT == 0) ? d : h2;
    h2 = h1;
    h1 = d;
    rise = s & ~sp;
    fall = ~s & sp;
    sp = s;
    m_err = 0;
    if (!e) begin
      m_active = 0; m_cand_vld = 0;
      m_ratio = '0; m_high = '0; m_valid = 0; m_stuck = 0;
    end else if (!m_active) begin
      m_active = 1; m_synced = 0; m_have_fall = 0; m_last_edge = m_t;
    end else if (rise || fall) begin
      m_stuck = 0;
      m_last_edge = m_t;
      if (rise) begin
        if (m_synced && m_have_fall) model_period(m_fall_t - m_rise_t, m_t - m_fall_t);
        m_synced = 1; m_rise_t = m_t; m_have_fall = 0;
      end else if (m_synced) begin
        m_fall_t = m_t; m_have_fall = 1;
      end
    end else if (m_t - m_last_edge >= CNT_MAX) begin
      m_stuck = 1; m_valid = 0; m_cand_vld = 0; m_synced = 0;
    end
    m_t++;
  endtask

  // One reference cycle: score the outputs of the previous edge, then drive the next inputs.
  task cycle(input logic e, input logic d);
    @(negedge clk);
    total++;
    if ({ratio, high_cnt, valid, err, stuck} !== {m_ratio, m_high, m_valid, m_err, m_stuck}) begin
      bad++;
      $display("FAIL scoreboard cyc=%0d got ratio=%0d high=%0d valid=%0b err=%0b stuck=%0b exp ratio=%0d high=%0d valid=%0b err=%0b stuck=%0b",
               cyc, ratio, high_cnt, valid, err, stuck, m_ratio, m_high, m_valid, m_err, m_stuck);
    end
    if (err === 1'b1) err_seen++;
    if (valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (stuck === 1'b1 && first_stuck < 0) first_stuck = cyc;
    en = e;
    div_clk = d;
    model_step(e, d);
    cyc++;
  endtask

  task wave(input int hh, input int ll, input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < hh; i++) cycle(1'b1, 1'b1);
      for (int i = 0; i < ll; i++) cycle(1'b1, 1'b0);
    end
  endtask

  task test_reset();
    rst_n = 1'b1; en = 1'b0; div_clk = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({ratio, high_cnt, valid, err, stuck} !== '0) begin
      bad++;
      $display("FAIL reset_values got %b exp all zero", {ratio, high_cnt, valid, err, stuck});
    end
    repeat (3) cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0);
  endtask

  task test_lock_ratio4();
    int r;
    cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    first_valid = -1; err_seen = 0; r = cyc;
    wave(2, 2, 6);
    total++;
    if (first_valid - r != LOCK4_LAT) begin
      bad++;
      $display("FAIL lock_latency got %0d exp %0d", first_valid - r, LOCK4_LAT);
    end
    total++;
    if ({valid, ratio, high_cnt} !== {1'b1, 4'd4, 4'd2}) begin
      bad++;
      $display("FAIL lock_ratio4 got valid=%0b ratio=%0d high=%0d exp 1/4/2", valid, ratio, high_cnt);
    end
    total++;
    if (err_seen != 0) begin
      bad++;
      $display("FAIL lock_no_err got %0d pulses exp 0", err_seen);
    end
  endtask

  task test_ratios();
    wave(2, 3, 5);
    total++;
    if ({valid, ratio, high_cnt} !== {1'b1, 4'd5, 4'd2}) begin
      bad++;
      $display("FAIL ratio5 got valid=%0b ratio=%0d high=%0d exp 1/5/2", valid, ratio, high_cnt);
    end
    wave(1, 1, 8);
    total++;
    if ({valid, ratio, high_cnt} !== {1'b1, 4'd2, 4'd1}) begin
      bad++;
      $display("FAIL ratio2 got valid=%0b ratio=%0d high=%0d exp 1/2/1", valid, ratio, high_cnt);
    end
    wave(7, 8, 4);
    total++;
    if ({valid, ratio, high_cnt} !== {1'b1, 4'd15, 4'd7}) begin
      bad++;
      $display("FAIL ratio15_max got valid=%0b ratio=%0d high=%0d exp 1/15/7", valid, ratio, high_cnt);
    end
  endtask

  task test_switch();
    wave(2, 2, 5);
    err_seen = 0;
    wave(3, 3, 3);
    total++;
    if (err_seen != 1) begin
      bad++;
      $display("FAIL switch_err_pulses got %0d exp 1", err_seen);
    end
    total++;
    if ({valid, ratio, high_cnt} !== {1'b1, 4'd6, 4'd3}) begin
      bad++;
      $display("FAIL switch_relock got valid=%0b ratio=%0d high=%0d exp 1/6/3", valid, ratio, high_cnt);
    end
  endtask

  task test_malformed();
    err_seen = 0;
    wave(3, 1, 6);
    total++;
    if (err_seen < 4) begin
      bad++;
      $display("FAIL malformed_err_pulses got %0d exp >=4", err_seen);
    end
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("FAIL malformed_valid got %0b exp 0", valid);
    end
  endtask

  task test_stuck();
    int r;
    wave(2, 2, 5);
    first_stuck = -1; r = cyc;
    repeat (20) cycle(1'b1, 1'b1);
    total++;
    if (first_stuck - r != STUCK_LAT) begin
      bad++;
      $display("FAIL stuck_latency got %0d exp %0d", first_stuck - r, STUCK_LAT);
    end
    total++;
    if ({stuck, valid} !== 2'b10) begin
      bad++;
      $display("FAIL stuck_level got stuck=%0b valid=%0b exp 1/0", stuck, valid);
    end
    wave(2, 2, 5);
    total++;
    if ({stuck, valid, ratio} !== {1'b0, 1'b1, 4'd4}) begin
      bad++;
      $display("FAIL stuck_recover got stuck=%0b valid=%0b ratio=%0d exp 0/1/4", stuck, valid, ratio);
    end
  endtask

  task test_edge_vs_timeout();
    first_stuck = -1; err_seen = 0;
    wave(1, 15, 3);
    total++;
    if (first_stuck != -1) begin
      bad++;
      $display("FAIL edge_beats_timeout got stuck at cyc %0d exp never", first_stuck);
    end
    total++;
    if (err_seen < 2) begin
      bad++;
      $display("FAIL period16_err got %0d pulses exp >=2", err_seen);
    end
  endtask

  task test_reset_and_en();
    int r;
    wave(2, 2, 5);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({ratio, high_cnt, valid, err, stuck} !== '0) begin
      bad++;
      $display("FAIL reset_mid_lock got %b exp all zero", {ratio, high_cnt, valid, err, stuck});
    end
    repeat (2) cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b0, 1'b0);
    repeat (3) cycle(1'b1, 1'b0);
    first_valid = -1; r = cyc;
    wave(2, 2, 6);
    total++;
    if (first_valid - r != LOCK4_LAT) begin
      bad++;
      $display("FAIL relock_latency got %0d exp %0d", first_valid - r, LOCK4_LAT);
    end
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    total++;
    if ({ratio, high_cnt, valid, err, stuck} !== '0) begin
      bad++;
      $display("FAIL en_low_clear got %b exp all zero", {ratio, high_cnt, valid, err, stuck});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      int kind, hh, ll, n;
      logic d;
      kind = int'($urandom_range(0, 9));
      if (kind < 5) begin
        hh = int'($urandom_range(1, 7));
        ll = hh + int'($urandom_range(0, 1));
        n  = int'($urandom_range(2, 5));
        wave(hh, ll, n);
      end else if (kind < 7) begin
        hh = int'($urandom_range(1, 9));
        ll = int'($urandom_range(1, 9));
        n  = int'($urandom_range(1, 3));
        wave(hh, ll, n);
      end else if (kind < 9) begin
        n = int'($urandom_range(1, 20));
        d = 1'($urandom_range(0, 1));
        repeat (n) cycle(1'b1, d);
      end else begin
        n = int'($urandom_range(1, 3));
        repeat (n) cycle(1'b0, 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_ratio4();
    test_ratios();
    test_switch();
    test_malformed();
    test_stuck();
    test_edge_vs_timeout();
    test_reset_and_en();
    test_random();
    cycle(1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/clk_ratio_det.md
# clk_ratio_det

Divided-clock ratio detector: samples a divided clock in the reference clock domain, measures its high and low run lengths, and reports the recovered division ratio once two consecutive well-formed periods agree. It is the checking end of the clock divider path, used for on-chip monitoring of the UART/peripheral clocks and as a self-check in DFT and bring-up. It flags malformed waveforms and a stuck clock, including the divider's bypass case, where the output is the reference clock itself.

## Interface
- RATIO_WIDTH, 4, width of the ratio and run counters; largest detectable period is 2^RATIO_WIDTH-1
- i_ref_clk  input  1  reference clock; all logic on its rising edge
- i_rst_n  input  1  reset, asynchronous, active-low
- i_en  input  1  detector enable; low forces IDLE
- i_div_clk  input  1  divided clock under test, sampled as data
- o_ratio  output  RATIO_WIDTH  locked period in i_ref_clk cycles (H+L)
- o_high_cnt  output  RATIO_WIDTH  high run length H of the locked waveform
- o_valid  output  1  o_ratio/o_high_cnt hold a locked measurement
- o_err  output  1  one-cycle pulse: period mismatch or malformed duty
- o_stuck  output  1  no edge for 2^RATIO_WIDTH-1 cycles; level signal

## Operation
- Edge detect: s = sampled input, s_q = s delayed one cycle; rise = s & ~s_q, fall = ~s & s_q.
- States: IDLE, SYNC, HIGH, LOW.
  - IDLE: i_en=0; counters and outputs cleared; i_en=1 -> SYNC.
  - SYNC: wait for rise -> HIGH, run counter loaded with 1.
  - HIGH: counter increments each cycle; on fall capture H=counter, reload 1 -> LOW.
  - LOW: counter increments; on rise capture L=counter, evaluate period, reload 1 -> HIGH.
- Period evaluation (P = H+L, RATIO_WIDTH+1 bits):
  - Well-formed: L-H in {0,1} and P <= 2^RATIO_WIDTH-1. Otherwise pulse o_err, clear o_valid and candidate.
  - First well-formed period after SYNC/err: store as candidate, no o_err.
  - Later well-formed P equal to candidate: o_valid=1, o_ratio=P, o_high_cnt=H.
  - Later well-formed P differing: pulse o_err, clear o_valid, new P becomes candidate.
- Timeout: in HIGH, LOW or SYNC, counter (or idle cycle count in SYNC) reaching 2^RATIO_WIDTH-1 without an edge sets o_stuck, clears o_valid and candidate -> SYNC. o_stuck clears on the next detected edge.
- i_en falling at any time -> IDLE next cycle, all outputs 0.

## Timing
- Reset values: o_ratio=0, o_high_cnt=0, o_valid=0, o_err=0, o_stuck=0, state IDLE, s_q=0.
- Outputs registered; update on the i_ref_clk edge that ends the cycle in which rise is detected.
- Lock latency from the first rise seen in SYNC: two full periods plus 1 cycle, i.e. o_valid rises 1 cycle after the third rise.
- o_err is exactly one cycle wide; o_valid falls in the same cycle o_err is asserted.
- A rise and timeout in the same cycle: edge wins, no o_stuck.
- Ratio 0/1 bypass (input equals i_ref_clk) samples constant -> o_stuck after 2^RATIO_WIDTH-1 cycles.
- Reset mid-measurement: immediate return to reset values; relock requires full latency.

## Configuration
- CLK_RATIO_DET_SYNC_EN defined: i_div_clk passes a 2-flop synchronizer before edge detect; all latencies +2 cycles; safe for asynchronous sources.
- Undefined: i_div_clk sampled directly, for sources already synchronous to i_ref_clk.

## Test plan
- RATIO_WIDTH=4, steady ratio 4 (H=2, L=2) after i_en=1 -> o_valid 1 cycle after third rise, o_ratio=4, o_high_cnt=2, o_err never.
- Steady ratio 5 (H=2, L=3) -> o_ratio=5, o_high_cnt=2; ratio 2 (H=1, L=1) -> o_ratio=2.
- Locked at 4, switch to 6 -> one o_err pulse, o_valid=0, relock o_ratio=6 after two 6-periods.
- Waveform H=3, L=1 -> o_err pulse each period, o_valid stays 0.
- i_div_clk held 1 for 20 cycles -> o_stuck=1 after 15 cycles without edge, o_valid=0; edges resume -> o_stuck clears, relock.
- i_rst_n low mid-lock, then i_en toggled low -> all outputs 0 immediately; with CLK_RATIO_DET_SYNC_EN, lock latency 2 cycles longer than without.
